reg_file8: RTL
==============

Name: reg_file8

Overview:
- 8 x 8-bit register file for the 8-bit single-cycle processor.
- Two combinational read ports (OUT1, OUT2) drive the ALU operand inputs (A, B): the OR, AND, ADD and MOV units.
- One synchronous write port receives the ALU result (C) for write-back.
- Tracks which registers have been written since reset, so the bench and later debug logic can flag reads of uninitialised registers.

Parameters:
- WIDTH, 8, data width of each register and of IN/OUT1/OUT2.
- DEPTH, 8, number of registers.
- ADDR_W, 3, address width; must satisfy 2**ADDR_W == DEPTH.
- BYPASS, 1, when 1 a same-cycle write is forwarded to a matching read port (write-first); when 0 the read returns the stored (old) value.

Ports:
- CLK  input  1  system clock; all state updates on rising edge.
- RESET_N  input  1  asynchronous, active-low reset.
- IN  input  WIDTH  write data (ALU result C), signed two's complement, stored as raw bits.
- INADDRESS  input  ADDR_W  write register index.
- WRITE  input  1  write enable, sampled at the rising CLK edge.
- OUT1ADDRESS  input  ADDR_W  read port 1 index.
- OUT2ADDRESS  input  ADDR_W  read port 2 index.
- OUT1  output  WIDTH  read port 1 data (ALU operand A).
- OUT2  output  WIDTH  read port 2 data (ALU operand B).
- VALID  output  DEPTH  bit i = 1 once register i has been written since the last reset.
- UNINIT1  output  1  OUT1ADDRESS selects a register whose VALID bit is 0.
- UNINIT2  output  1  OUT2ADDRESS selects a register whose VALID bit is 0.

Behaviour:
- Reset
  - RESET_N low clears all registers to 0 and VALID to 0 immediately, with no clock edge required.
  - OUT1 = OUT2 = 0, UNINIT1 = UNINIT2 = 1 while reset is held.
  - Reset asserted mid-cycle aborts any pending write; the write does not land on the next edge while RESET_N is low.
  - Writes resume at the first rising edge with RESET_N high.
- Write
  - At a rising CLK edge with RESET_N = 1 and WRITE = 1: reg[INADDRESS] <= IN and VALID[INADDRESS] <= 1.
  - WRITE = 0 leaves all state unchanged.
  - Write latency is 1 edge.
  - Writing the same value again is legal and keeps VALID at 1.
- Read
  - Purely combinational, zero-cycle latency: OUTx = reg[OUTxADDRESS].
  - Both ports may address the same register simultaneously; both return the same value.
- Bypass
  - When BYPASS = 1, WRITE = 1, RESET_N = 1 and OUTxADDRESS == INADDRESS: OUTx = IN and UNINITx = 0 before the edge.
  - When BYPASS = 0, the old value is returned until after the edge.
  - The same rule applies independently to each port.
- Simultaneous write and read of different addresses: no interaction.
- UNINITx = ~VALID[OUTxADDRESS], subject to the bypass override above.
- Addresses are full-range (DEPTH = 2**ADDR_W), so there is no out-of-range case.
- No register is hardwired; reg 0 is writable.
- X on WRITE at an edge is a bench error; RTL need not define the result.

Decomposition:
- Shared package (processor-wide constants): WIDTH, DEPTH, ADDR_W.
- One natural sub-module: reg_file8_read_port, instantiated twice.
  - Inputs: address, storage array, VALID, write bundle.
  - Outputs: data and UNINIT.
  - Contains the mux and the BYPASS forwarding logic.
- Storage, VALID and write logic live in the top module.

Test Plan:
- Reset then idle: RESET_N = 0 for 2 cycles, release, OUT1ADDRESS = 0, OUT2ADDRESS = 7 -> OUT1 = 0, OUT2 = 0, UNINIT1 = UNINIT2 = 1, VALID = 8'h00.
- Basic write/read: WRITE = 1, INADDRESS = 3, IN = 8'b11010100, one edge, then WRITE = 0, OUT1ADDRESS = 3 -> OUT1 = 8'hD4 (-44 signed), VALID = 8'h08, UNINIT1 = 0.
- Dual read of one register: write reg 5 = 15, OUT1ADDRESS = OUT2ADDRESS = 5 -> OUT1 = OUT2 = 15.
- Feed to OrUnit8: write reg 1 = 15 and reg 2 = 11, read them to A/B -> C = 15.
- Bypass:
  - BYPASS = 1: reg 2 holds 10; drive WRITE = 1, INADDRESS = 2, IN = 99, OUT1ADDRESS = 2 before the edge -> OUT1 = 99, then 99 after the edge.
  - BYPASS = 0: same stimulus -> OUT1 = 10 before the edge, 99 after.
- Async reset mid-operation: reg 4 = 1 and reg 6 = 77 written, assert RESET_N = 0 between edges while WRITE = 1, INADDRESS = 0, IN = 5 -> OUT immediately 0, VALID = 0, and reg 0 still 0 after release.

Source files
------------

// File: rtl/reg_file8_pkg.sv
// rtl/reg_file8_pkg.sv - processor-wide constants for the 8-bit register file
package reg_file8_pkg;

  localparam int RF_WIDTH  = 8;
  localparam int RF_DEPTH  = 8;
  localparam int RF_ADDR_W = 3;

  typedef logic [RF_WIDTH-1:0]  word_t;
  typedef logic [RF_ADDR_W-1:0] addr_t;

endpackage

// File: rtl/reg_file8_read_port.sv
// rtl/reg_file8_read_port.sv - combinational read mux with optional write-first forwarding
module reg_file8_read_port
  import reg_file8_pkg::*;
#(
  parameter int WIDTH  = RF_WIDTH,
  parameter int DEPTH  = RF_DEPTH,
  parameter int ADDR_W = RF_ADDR_W,
  parameter int BYPASS = 1
) (
  input  logic [ADDR_W-1:0]            addr,
  input  logic [DEPTH-1:0][WIDTH-1:0]  regs,
  input  logic [DEPTH-1:0]             valid,
  input  logic                         wr_en,
  input  logic [ADDR_W-1:0]            wr_addr,
  input  logic [WIDTH-1:0]             wr_data,
  output logic [WIDTH-1:0]             data,
  output logic                         uninit
);

  localparam bit FORWARD = (BYPASS != 0);

  logic hit;

  always_comb begin
    // wr_en already carries the reset gate, so reset never forwards stale write data
    hit    = FORWARD && wr_en && (addr == wr_addr);
    data   = hit ? wr_data : regs[addr];
    uninit = hit ? 1'b0 : ~valid[addr];
  end

endmodule

// File: rtl/reg_file8.sv
// rtl/reg_file8.sv - 8x8 register file, two combinational read ports, one write port
module reg_file8
  import reg_file8_pkg::*;
#(
  parameter int WIDTH  = RF_WIDTH,
  parameter int DEPTH  = RF_DEPTH,
  parameter int ADDR_W = RF_ADDR_W,
  parameter int BYPASS = 1
) (
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic [WIDTH-1:0]  IN,
  input  logic [ADDR_W-1:0] INADDRESS,
  input  logic              WRITE,
  input  logic [ADDR_W-1:0] OUT1ADDRESS,
  input  logic [ADDR_W-1:0] OUT2ADDRESS,
  output logic [WIDTH-1:0]  OUT1,
  output logic [WIDTH-1:0]  OUT2,
  output logic [DEPTH-1:0]  VALID,
  output logic              UNINIT1,
  output logic              UNINIT2
);

  logic [DEPTH-1:0][WIDTH-1:0] regs;
  logic [DEPTH-1:0]            valid;
  logic                        wr_live;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      regs  <= '0;
      valid <= '0;
    end else if (WRITE) begin
      regs[INADDRESS]  <= IN;
      valid[INADDRESS] <= 1'b1;
    end
  end

  assign wr_live = WRITE & RESET_N;
  assign VALID   = valid;

  reg_file8_read_port #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .BYPASS(BYPASS)
  ) u_port1 (
    .addr    (OUT1ADDRESS),
    .regs    (regs),
    .valid   (valid),
    .wr_en   (wr_live),
    .wr_addr (INADDRESS),
    .wr_data (IN),
    .data    (OUT1),
    .uninit  (UNINIT1)
  );

  reg_file8_read_port #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .BYPASS(BYPASS)
  ) u_port2 (
    .addr    (OUT2ADDRESS),
    .regs    (regs),
    .valid   (valid),
    .wr_en   (wr_live),
    .wr_addr (INADDRESS),
    .wr_data (IN),
    .data    (OUT2),
    .uninit  (UNINIT2)
  );

endmodule
